uart_rx_fifo: RTL and testbench

- Receives the asynchronous serial byte stream that the USB CDC bridge drives out on its UART receive line.
- Deserialises 8N1 frames at BAUDRATE in the 60 MHz ULPI clock domain.
- Buffers received bytes in a small FIFO and presents them to fabric logic over a valid/accept handshake.
- Sits directly downstream of the USB serial top-level, consuming its uart_rx_o output.

---
 rtl/uart_rx_fifo.sv | 171 +++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// The serial line is synchronised into clk_i before any framing decision.
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 60000000,
    parameter int BAUDRATE   = 1000000,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          rx_i,
    output logic [7:0]                    data_o,
    output logic                          valid_o,
    input  logic                          accept_i,
    output logic                          frame_err_o,
    output logic                          overflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int DIV  = CLK_FREQ / BAUDRATE;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int LW   = AW + 1;

    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [LW-1:0] FULL_LV = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic [1:0]    sync_q, sync_d;
    logic          rx_s;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          fe_q, fe_d;
    logic          ov_q, ov_d;
    logic          push;

    logic [LW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level;
    logic          full;
    logic          pop;
    logic          wr_en;
    logic [7:0]    mem_q [FIFO_DEPTH];

    // Two-stage synchroniser; the line idles high, so both stages reset to 1.
    always_comb begin
        sync_d = {sync_q[0], rx_i};
    end

    assign rx_s = sync_q[1];

    // Frame FSM: start qualification, mid-bit sampling, stop check, break wait.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        push    = 1'b0;
        fe_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    cnt_d   = HALF_M1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (!rx_s) begin
                    cnt_d   = DIV_M1;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    shift_d = {rx_s, shift_q[7:1]};
                    cnt_d   = DIV_M1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (rx_s) begin
                    push    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    fe_d    = 1'b1;
                    state_d = S_BREAK;
                end
            end
            S_BREAK: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO control: a pop frees the slot a same-cycle push into a full FIFO needs.
    always_comb begin
        level    = wr_ptr_q - rd_ptr_q;
        full     = (level == FULL_LV);
        pop      = (level != '0) & accept_i;
        wr_en    = push & (~full | pop);
        ov_d     = push & full & ~pop;
        wr_ptr_d = wr_ptr_q + LW'(wr_en);
        rd_ptr_d = rd_ptr_q + LW'(pop);
    end

    // Control and status registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q   <= 2'b11;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            fe_q     <= 1'b0;
            ov_q     <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            sync_q   <= sync_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            fe_q     <= fe_d;
            ov_q     <= ov_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Byte storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
        end
    end

    assign valid_o     = (level != '0);
    assign data_o      = valid_o ? mem_q[rd_ptr_q[AW-1:0]] : 8'h00;
    assign level_o     = level;
    assign frame_err_o = fe_q;
    assign overflow_o  = ov_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed frames against a queue model of the receiver+FIFO.
// The model knows when each stop bit is sampled and what the FIFO must hold.
module tb_uart_rx_fifo;

    localparam int DIV      = 60;
    localparam int HALF     = 30;
    localparam int DEPTH    = 16;
    localparam int STOP_LAT = HALF + 3 + 9 * DIV;

    typedef struct {
        int         at;
        logic [7:0] b;
        bit         fe;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       rx_i;
    logic       accept_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overflow_o;
    logic [4:0] level_o;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    ev_t        pend[$];
    logic [7:0] mq[$];
    bit         exp_fe = 1'b0;
    bit         exp_ov = 1'b0;
    logic [7:0] got [64];
    int         got_n;

    uart_rx_fifo dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .accept_i    (accept_i),
        .frame_err_o (frame_err_o),
        .overflow_o  (overflow_o),
        .level_o     (level_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h",
                     nm, cyc, a, e);
        end
    endtask

    // Model: each posedge applies the pop request, then any scheduled frame outcome.
    always @(posedge clk) begin
        bit         pop, push, ferr, full;
        logic [7:0] pb;
        cyc++;
        pop  = accept_i && (mq.size() > 0);
        full = (mq.size() == DEPTH);
        push = 1'b0;
        ferr = 1'b0;
        pb   = 8'h00;
        if (pend.size() > 0 && pend[0].at == cyc) begin
            if (pend[0].fe) ferr = 1'b1;
            else begin
                push = 1'b1;
                pb   = pend[0].b;
            end
            void'(pend.pop_front());
        end
        exp_fe = ferr;
        exp_ov = 1'b0;
        if (rst_i) begin
            mq.delete();
            pend.delete();
            exp_fe = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                if (full && !pop) exp_ov = 1'b1;
                else mq.push_back(pb);
            end
        end
    end

    // Every cycle: outputs against the model.
    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("valid", 32'(valid_o), 32'(mq.size() > 0));
            chk("level", 32'(level_o), 32'(mq.size()));
            chk("frame_err", 32'(frame_err_o), 32'(exp_fe));
            chk("overflow", 32'(overflow_o), 32'(exp_ov));
            if (mq.size() > 0) chk("data", 32'(data_o), 32'(mq[0]));
            if (frame_err_o === 1'b1) fe_cnt++;
            if (overflow_o === 1'b1) ov_cnt++;
        end
    end

    // Drives one frame starting now; abort_bit >= 0 resets mid-bit instead.
    task automatic send_frame(input logic [7:0] b, input bit stop,
                              input int per, input int abort_bit);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        if (abort_bit < 0) pend.push_back(ev_t'{cyc + STOP_LAT, b, !stop});
        for (int k = 0; k < 10; k++) begin
            rx_i = bits[k];
            if (k == abort_bit) begin
                repeat (per / 2) @(negedge clk);
                rx_i  = 1'b1;
                rst_i = 1'b1;
                @(negedge clk);
                rst_i = 1'b0;
                return;
            end
            repeat (per) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        got_n    = 0;
        accept_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (valid_o === 1'b1) begin
                got[got_n] = data_o;
                got_n++;
            end
            @(negedge clk);
        end
        accept_i = 1'b0;
    endtask

    initial begin
        int fe0, ov0;
        rst_i    = 1'b1;
        rx_i     = 1'b1;
        accept_i = 1'b0;
        idle(3);
        rst_i = 1'b0;
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_level", 32'(level_o), 32'd0);
        chk("rst_data", 32'(data_o), 32'd0);
        idle(5);

        // single byte, then one-cycle accept
        send_frame(8'h55, 1'b1, DIV, -1);
        chk("t1_valid", 32'(valid_o), 32'd1);
        chk("t1_data", 32'(data_o), 32'h55);
        chk("t1_level", 32'(level_o), 32'd1);
        accept_i = 1'b1;
        @(negedge clk);
        accept_i = 1'b0;
        chk("t1_pop_valid", 32'(valid_o), 32'd0);
        chk("t1_pop_level", 32'(level_o), 32'd0);

        // false start, then a good frame
        fe0  = fe_cnt;
        rx_i = 1'b0;
        idle(10);
        rx_i = 1'b1;
        idle(100);
        chk("t2_level", 32'(level_o), 32'd0);
        chk("t2_fe", 32'(fe_cnt - fe0), 32'd0);
        send_frame(8'hA3, 1'b1, DIV, -1);
        idle(5);
        drain();
        chk("t2_n", 32'(got_n), 32'd1);
        chk("t2_byte", 32'(got[0]), 32'hA3);

        // framing error with held-low line
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0, DIV, -1);
        idle(2 * DIV);
        rx_i = 1'b1;
        idle(2 * DIV);
        chk("t3_fe_pulses", 32'(fe_cnt - fe0), 32'd1);
        chk("t3_level", 32'(level_o), 32'd0);
        send_frame(8'h81, 1'b1, DIV, -1);
        idle(5);
        drain();
        chk("t3_n", 32'(got_n), 32'd1);
        chk("t3_byte", 32'(got[0]), 32'h81);

        // overflow: 17 back-to-back frames, no accept
        ov0 = ov_cnt;
        for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1, DIV, -1);
        idle(5);
        chk("t4_level", 32'(level_o), 32'd16);
        chk("t4_ov_pulses", 32'(ov_cnt - ov0), 32'd1);
        drain();
        chk("t4_n", 32'(got_n), 32'd16);
        for (int i = 0; i < 16; i++) chk("t4_order", 32'(got[i]), 32'(i));
        chk("t4_empty", 32'(valid_o), 32'd0);

        // full FIFO with a pop on the 17th stop sample
        ov0 = ov_cnt;
        for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1, DIV, -1);
        fork
            send_frame(8'h10, 1'b1, DIV, -1);
            begin
                repeat (STOP_LAT - 1) @(negedge clk);
                accept_i = 1'b1;
                @(negedge clk);
                accept_i = 1'b0;
            end
        join
        idle(5);
        chk("t5_level", 32'(level_o), 32'd16);
        chk("t5_ov_pulses", 32'(ov_cnt - ov0), 32'd0);
        drain();
        chk("t5_n", 32'(got_n), 32'd16);
        for (int i = 0; i < 16; i++) chk("t5_order", 32'(got[i]), 32'(i + 1));

        // reset in the middle of data bit 4 with 3 bytes buffered
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        send_frame(8'h11, 1'b1, DIV, -1);
        send_frame(8'h22, 1'b1, DIV, -1);
        send_frame(8'h33, 1'b1, DIV, -1);
        idle(5);
        chk("t6_pre_level", 32'(level_o), 32'd3);
        send_frame(8'h99, 1'b1, DIV, 5);
        chk("t6_level", 32'(level_o), 32'd0);
        chk("t6_valid", 32'(valid_o), 32'd0);
        idle(2 * DIV);
        send_frame(8'hC7, 1'b1, DIV, -1);
        idle(5);
        drain();
        chk("t6_n", 32'(got_n), 32'd1);
        chk("t6_byte", 32'(got[0]), 32'hC7);

        // transmitter 2% fast and 2% slow
        send_frame(8'h5A, 1'b1, 59, -1);
        idle(DIV);
        send_frame(8'h5A, 1'b1, 61, -1);
        idle(5);
        drain();
        chk("t7_n", 32'(got_n), 32'd2);
        chk("t7_fast", 32'(got[0]), 32'h5A);
        chk("t7_slow", 32'(got[1]), 32'h5A);
        chk("t6_t7_fe", 32'(fe_cnt - fe0), 32'd0);
        chk("t6_t7_ov", 32'(ov_cnt - ov0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
